i_serdes_word_aligner: RTL



---
 rtl/i_serdes_word_aligner.sv | 123 ++++++++++++
 1 files changed

// File: rtl/i_serdes_word_aligner.sv
// i_serdes_word_aligner: fabric-side word-boundary training controller for the
// I_SERDES receive path. It compares valid deserialized words with a training
// pattern and requests single-cycle bitslips until the boundary matches. It then
// reports lock, or reports an error once 2*WIDTH slips have been spent.
//
// Ports:
//   CLK_IN       fabric clock (I_SERDES CLK_OUT domain)
//   RST          synchronous reset, active-low
//   EN           alignment enable; low aborts to idle
//   DPA_LOCK     deserializer DPA lock; low aborts to idle
//   Q            deserialized word, qualified by DATA_VALID
//   DATA_VALID   Q qualifier
//   BITSLIP_ADJ  one-cycle slip request to I_SERDES (registered)
//   ALIGNED      high while locked (registered)
//   ALIGN_ERROR  high once every slip position failed (registered)
//   SLIP_COUNT   slips issued in the current attempt, saturating at 2*WIDTH
module i_serdes_word_aligner #(
   parameter int unsigned WIDTH            = 4,
   parameter logic [9:0]  TRAINING_PATTERN = 10'b0000000011,
   parameter int unsigned MATCH_COUNT      = 8,
   parameter int unsigned SLIP_WAIT        = 4
) (
   input  logic             CLK_IN,
   input  logic             RST,
   input  logic             EN,
   input  logic             DPA_LOCK,
   input  logic [WIDTH-1:0] Q,
   input  logic             DATA_VALID,
   output logic             BITSLIP_ADJ,
   output logic             ALIGNED,
   output logic             ALIGN_ERROR,
   output logic [4:0]       SLIP_COUNT
);

   localparam logic [WIDTH-1:0] PATTERN    = TRAINING_PATTERN[WIDTH-1:0];
   localparam logic [4:0]       SLIP_LIMIT = 5'(2 * WIDTH);
   localparam logic [7:0]       MATCH_LAST = 8'(MATCH_COUNT - 1);
   localparam logic [3:0]       WAIT_LAST  = 4'(SLIP_WAIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_SLIP,
      S_WAIT,
      S_LOCKED,
      S_FAIL
   } state_t;

   state_t     state;
   logic [7:0] match_cnt;
   logic [3:0] wait_cnt;

   // Training state machine; every output is a register updated here.
   always_ff @(posedge CLK_IN) begin
      if (!RST || !EN || !DPA_LOCK) begin
         // Reset and abort share one clean-restart path.
         state       <= S_IDLE;
         BITSLIP_ADJ <= 1'b0;
         ALIGNED     <= 1'b0;
         ALIGN_ERROR <= 1'b0;
         SLIP_COUNT  <= 5'd0;
         match_cnt   <= 8'd0;
         wait_cnt    <= 4'd0;
      end else begin
         case (state)
            S_IDLE: begin
               match_cnt <= 8'd0;
               wait_cnt  <= 4'd0;
               state     <= S_CHECK;
            end
            S_CHECK: begin
               if (DATA_VALID) begin
                  if (Q == PATTERN) begin
                     match_cnt <= match_cnt + 8'd1;
                     if (match_cnt == MATCH_LAST) begin
                        state   <= S_LOCKED;
                        ALIGNED <= 1'b1;
                     end
                  end else begin
                     match_cnt <= 8'd0;
                     if (SLIP_COUNT == SLIP_LIMIT) begin
                        state       <= S_FAIL;
                        ALIGN_ERROR <= 1'b1;
                     end else begin
                        state       <= S_SLIP;
                        BITSLIP_ADJ <= 1'b1;
                     end
                  end
               end
            end
            S_SLIP: begin
               // Pulse lasts exactly this cycle; count the slip as it retires.
               BITSLIP_ADJ <= 1'b0;
               if (SLIP_COUNT < SLIP_LIMIT) begin
                  SLIP_COUNT <= SLIP_COUNT + 5'd1;
               end
               wait_cnt <= 4'd0;
               state    <= S_WAIT;
            end
            S_WAIT: begin
               // Discard words still in flight from before the slip.
               if (DATA_VALID) begin
                  wait_cnt <= wait_cnt + 4'd1;
                  if (wait_cnt == WAIT_LAST) begin
                     match_cnt <= 8'd0;
                     state     <= S_CHECK;
                  end
               end
            end
            S_LOCKED: begin
               ALIGNED <= 1'b1;
            end
            S_FAIL: begin
               ALIGN_ERROR <= 1'b1;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
